// File: rtl/fp16_pkg.sv
// Shared fp16 constants, result flag positions and the divide sequencer state type.
package fp16_pkg;

    localparam logic [15:0] FP16_QNAN    = 16'h7E00;
    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;

    localparam int FLAG_DZ = 0;
    localparam int FLAG_TO = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        CLEAR  = 3'd3,
        BYPASS = 3'd4
    } div_seq_state_t;

    // Signed infinity with the given sign bit.
    function automatic logic [15:0] fp16_inf(input logic sign);
        return {sign, FP16_EXP_MAX, 10'h000};
    endfunction

endpackage

// File: rtl/fp16_result_fifo.sv
// Generic synchronous FIFO holding {flags, result} entries for the divide sequencer.
module fp16_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        push,
    input  logic [17:0] push_data,
    input  logic        pop,
    output logic [17:0] head,
    output logic        full,
    output logic        not_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [17:0]   mem_q [DEPTH];
    logic [17:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push && !full;
        pop_ok   = pop && not_empty;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fp16_div_sequencer.sv
// Sequences one fp16 divide at a time through an external divider, short-circuits
// zero divisors, aborts stuck divides after TIMEOUT wait cycles, and queues results.
module fp16_div_sequencer
    import fp16_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] div_a,
    output logic [15:0] div_b,
    output logic        div_start,
    output logic        div_clear,
    input  logic        div_valid,
    input  logic [15:0] div_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic [1:0]  out_flags
);

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0]    FLAGS_DZ = 2'(1 << FLAG_DZ);
    localparam logic [1:0]    FLAGS_TO = 2'(1 << FLAG_TO);

    div_seq_state_t state_q, state_d;
    logic [15:0]    a_q, a_d;
    logic [15:0]    b_q, b_d;
    logic [15:0]    res_q, res_d;
    logic [1:0]     flg_q, flg_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           fifo_push;
    logic [17:0]    fifo_push_data;
    logic [17:0]    fifo_head;
    logic           fifo_full;
    logic           fifo_not_empty;
    logic           accept;

    assign in_ready   = reset_b && (state_q == IDLE) && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign div_a      = a_q;
    assign div_b      = b_q;
    assign div_start  = (state_q == ISSUE);
    assign div_clear  = (state_q == CLEAR);
    assign out_valid  = fifo_not_empty;
    assign out_result = fifo_head[15:0];
    assign out_flags  = fifo_head[17:16];

    // Next-state, operand latch, result capture and FIFO push decode.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        res_d          = res_q;
        flg_d          = flg_q;
        cnt_d          = cnt_q;
        fifo_push      = 1'b0;
        fifo_push_data = {flg_q, res_q};
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = (in_b[14:0] == 15'h0) ? BYPASS : ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (div_valid) begin
                    res_d   = div_result;
                    flg_d   = 2'b00;
                    state_d = CLEAR;
                end else if (cnt_q == CNT_LAST) begin
                    res_d   = FP16_QNAN;
                    flg_d   = FLAGS_TO;
                    state_d = CLEAR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CLEAR: begin
                fifo_push = 1'b1;
                state_d   = IDLE;
            end
            BYPASS: begin
                // 0/0 is NaN; anything else over zero is infinity signed by the operand signs.
                fifo_push = 1'b1;
                if (a_q[14:0] == 15'h0) begin
                    fifo_push_data = {FLAGS_DZ, FP16_QNAN};
                end else begin
                    fifo_push_data = {FLAGS_DZ, fp16_inf(a_q[15] ^ b_q[15])};
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= IDLE;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            res_q   <= 16'h0000;
            flg_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            cnt_q   <= cnt_d;
        end
    end

    fp16_result_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_b   (reset_b),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (out_valid && out_ready),
        .head      (fifo_head),
        .full      (fifo_full),
        .not_empty (fifo_not_empty)
    );

endmodule

// File: tb/tb_fp16_div_sequencer.sv
// Bench for fp16_div_sequencer: divider stub, queue-based result model, directed scenarios.
module tb_fp16_div_sequencer;

    logic        clk;
    logic        reset_b;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] div_a;
    logic [15:0] div_b;
    logic        div_start;
    logic        div_clear;
    logic        div_valid;
    logic [15:0] div_result;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_flags;

    logic        stub_valid = 1'b0;
    logic        stray_valid;
    logic [15:0] stub_res = 16'h0000;
    int          stub_cnt = 0;
    int          stub_never;

    assign div_valid  = stub_valid | stray_valid;
    assign div_result = stub_res;

    int          cmp = 0;
    int          err = 0;
    logic [17:0] q[$];
    int          pcyc = 0;
    int          dv_edge = -1;
    int          pop_cnt = 0;
    int          start_cnt = 0;
    int          clear_cnt = 0;
    int          start_at = -1;
    int          clear_at = -1;
    int          ov_rise_at = -1;
    logic        prev_start = 1'b0;
    logic        prev_clear = 1'b0;
    logic        prev_ov = 1'b0;

    fp16_div_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .div_a      (div_a),
        .div_b      (div_b),
        .div_start  (div_start),
        .div_clear  (div_clear),
        .div_valid  (div_valid),
        .div_result (div_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Quotients the stub divider knows (exact fp16 values).
    function automatic logic [15:0] ref_quot(input logic [15:0] a, input logic [15:0] b);
        if (a == 16'h4600 && b == 16'h4000) return 16'h4200;  // 6/2 = 3
        if (a == 16'h4000 && b == 16'h3C00) return 16'h4000;  // 2/1 = 2
        if (a == 16'h3C00 && b == 16'h4000) return 16'h3800;  // 1/2 = 0.5
        if (a == 16'h4400 && b == 16'h4000) return 16'h4000;  // 4/2 = 2
        return a ^ b;
    endfunction

    // What the sequencer must eventually deliver for one accepted operation.
    function automatic logic [17:0] expect_entry(input logic [15:0] a, input logic [15:0] b,
                                                 input logic never);
        if (b[14:0] == 15'h0) begin
            if (a[14:0] == 15'h0) return {2'b01, 16'h7E00};
            return {2'b01, a[15] ^ b[15], 5'h1F, 10'h0};
        end
        if (never) return {2'b10, 16'h7E00};
        return {2'b00, ref_quot(a, b)};
    endfunction

    // Divider stub: answers 5 cycles after div_start unless told never to answer.
    initial begin
        forever begin
            @(negedge clk);
            stub_valid = 1'b0;
            if (reset_b !== 1'b1) begin
                stub_cnt = 0;
            end else if (div_start === 1'b1 && stub_never == 0) begin
                stub_cnt = 5;
                stub_res = ref_quot(div_a, div_b);
            end else if (stub_cnt > 0) begin
                stub_cnt = stub_cnt - 1;
                if (stub_cnt == 0) stub_valid = 1'b1;
            end
        end
    end

    // Model update on every active edge: acceptances enqueue, pops dequeue, reset flushes.
    initial begin
        forever begin
            @(posedge clk);
            pcyc = pcyc + 1;
            if (reset_b !== 1'b1) begin
                q.delete();
            end else begin
                if (div_valid === 1'b1) dv_edge = pcyc;
                if (out_valid === 1'b1 && out_ready === 1'b1 && q.size() > 0) begin
                    void'(q.pop_front());
                    pop_cnt = pop_cnt + 1;
                end
                if (in_valid === 1'b1 && in_ready === 1'b1)
                    q.push_back(expect_entry(in_a, in_b, stub_never != 0));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp = cmp + 1;
        if (act !== exp) begin
            err = err + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare everything observable there.
    task automatic tick();
        @(negedge clk);
        if (reset_b === 1'b1 && out_valid === 1'b1) begin
            cmp = cmp + 1;
            if (q.size() == 0) begin
                err = err + 1;
                $display("FAIL model_head: out_valid=1 result %h, required no output", out_result);
            end else if ({out_flags, out_result} !== q[0]) begin
                err = err + 1;
                $display("FAIL model_head: got %h required %h", {out_flags, out_result}, q[0]);
            end
        end
        if (div_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_at  = pcyc;
            chk("div_start_one_cycle", {31'h0, prev_start}, 0);
        end
        if (div_clear === 1'b1) begin
            clear_cnt = clear_cnt + 1;
            clear_at  = pcyc;
            chk("div_clear_one_cycle", {31'h0, prev_clear}, 0);
        end
        if (out_valid === 1'b1 && !prev_ov) ov_rise_at = pcyc;
        prev_start = (div_start === 1'b1);
        prev_clear = (div_clear === 1'b1);
        prev_ov    = (out_valid === 1'b1);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("accept", {31'h0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input int bound);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk({name, "_seen"}, {31'h0, out_valid}, 1);
    endtask

    task automatic bypass(input logic [15:0] a, input logic [15:0] b, input logic [15:0] r);
        send(a, b);
        chk("bypass_not_yet", {31'h0, out_valid}, 0);
        tick();
        chk("bypass_valid", {31'h0, out_valid}, 1);
        chk("bypass_result", {16'h0, out_result}, {16'h0, r});
        chk("bypass_flags", {30'h0, out_flags}, 1);
        tick();
    endtask

    initial begin
        int s0, c0, p0, n;
        reset_b     = 1'b0;
        in_valid    = 1'b0;
        in_a        = 16'h0;
        in_b        = 16'h0;
        out_ready   = 1'b1;
        stray_valid = 1'b0;
        stub_never  = 0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_div_start", {31'h0, div_start}, 0);
        chk("rst_div_clear", {31'h0, div_clear}, 0);
        chk("rst_div_a", {16'h0, div_a}, 0);
        chk("rst_div_b", {16'h0, div_b}, 0);
        reset_b = 1'b1;
        #1;
        chk("in_ready_after_reset", {31'h0, in_ready}, 1);
        tick();

        // Normal divide 6.0 / 2.0
        s0 = start_cnt;
        c0 = clear_cnt;
        send(16'h4600, 16'h4000);
        chk("issue_div_start", {31'h0, div_start}, 1);
        chk("issue_div_a", {16'h0, div_a}, 32'h4600);
        chk("issue_div_b", {16'h0, div_b}, 32'h4000);
        wait_out("normal", 50);
        chk("normal_result", {16'h0, out_result}, 32'h4200);
        chk("normal_flags", {30'h0, out_flags}, 0);
        chk("normal_clear_latency", clear_at, dv_edge);
        chk("normal_out_latency", ov_rise_at, dv_edge + 1);
        chk("normal_start_pulses", start_cnt - s0, 1);
        chk("normal_clear_pulses", clear_cnt - c0, 1);
        tick();

        // Divide by zero
        s0 = start_cnt;
        bypass(16'h3C00, 16'h0000, 16'h7C00);
        bypass(16'hBC00, 16'h8000, 16'h7C00);
        bypass(16'h0000, 16'h8000, 16'h7E00);
        chk("dz_no_start", start_cnt - s0, 0);

        // Timeout
        stub_never = 1;
        c0 = clear_cnt;
        send(16'h4400, 16'h4000);
        wait_out("timeout", 200);
        chk("timeout_result", {16'h0, out_result}, 32'h7E00);
        chk("timeout_flags", {30'h0, out_flags}, 2);
        chk("timeout_wait_cycles", clear_at - start_at, 65);
        chk("timeout_clear_pulses", clear_cnt - c0, 1);
        chk("timeout_in_ready", {31'h0, in_ready}, 1);
        tick();
        stub_never = 0;

        // Backpressure: four fill the FIFO, the fifth waits for a pop
        out_ready = 1'b0;
        p0 = pop_cnt;
        send(16'h4600, 16'h4000);
        send(16'h4000, 16'h3C00);
        send(16'hC000, 16'h0000);
        send(16'h3C00, 16'h4000);
        repeat (12) tick();
        in_a     = 16'h4400;
        in_b     = 16'h4000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_in_ready", {31'h0, in_ready}, 0);
        end
        chk("full_head", {14'h0, out_flags, out_result}, 32'h04200);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("popped_head", {14'h0, out_flags, out_result}, 32'h04000);
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("fifth_accept", {31'h0, in_ready}, 1);
        tick();
        in_valid = 1'b0;
        repeat (12) tick();
        out_ready = 1'b1;
        n = 0;
        while ((q.size() > 0 || out_valid === 1'b1) && n < 50) begin
            tick();
            n++;
        end
        chk("drain_pops", pop_cnt - p0, 5);
        chk("drain_empty", {31'h0, out_valid}, 0);

        // Reset in the middle of WAIT
        stub_never = 1;
        send(16'h4600, 16'h4000);
        repeat (10) tick();
        c0 = clear_cnt;
        reset_b = 1'b0;
        tick();
        reset_b = 1'b1;
        #1;
        chk("midrst_out_valid", {31'h0, out_valid}, 0);
        chk("midrst_in_ready", {31'h0, in_ready}, 1);
        chk("midrst_div_a", {16'h0, div_a}, 0);
        tick();
        chk("midrst_in_ready_next", {31'h0, in_ready}, 1);
        chk("midrst_no_clear", clear_cnt - c0, 0);
        stub_never = 0;
        send(16'h4600, 16'h4000);
        wait_out("after_reset", 50);
        chk("after_reset_result", {16'h0, out_result}, 32'h4200);
        chk("after_reset_flags", {30'h0, out_flags}, 0);
        tick();

        // Stray div_valid while idle
        tick();
        s0 = start_cnt;
        stray_valid = 1'b1;
        tick();
        stray_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_out_valid", {31'h0, out_valid}, 0);
            chk("stray_in_ready", {31'h0, in_ready}, 1);
        end
        chk("stray_no_start", start_cnt - s0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

endmodule
